// File: rtl/ldst_initiator.sv
// Lane load/store initiator: accepts a strided access command, requests the DMem
// load or store port, streams beats (stores from a local data FIFO) and pulses O_Done.
module ldst_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Cmd_Valid,
    input  logic              I_Cmd_Ld,
    input  logic [ADDR_W-1:0] I_Cmd_Length,
    input  logic [ADDR_W-1:0] I_Cmd_Stride,
    input  logic [ADDR_W-1:0] I_Cmd_Base,
    output logic              O_Cmd_Ready,
    input  logic              I_Wr_Valid,
    input  logic [DATA_W-1:0] I_Wr_Data,
    output logic              O_Wr_Ready,
    output logic              O_Rd_Valid,
    output logic [DATA_W-1:0] O_Rd_Data,
    output logic              O_Done,
    output logic              O_St_Req,
    output logic              O_Ld_Req,
    output logic [ADDR_W-1:0] O_Length,
    output logic [ADDR_W-1:0] O_Stride,
    output logic [ADDR_W-1:0] O_Base_Addr,
    input  logic              I_St_Grant,
    input  logic              I_Ld_Grant,
    input  logic              I_St_Ready,
    input  logic              I_Ld_Ready,
    output logic              O_St_Valid,
    output logic              O_Ld_Valid,
    output logic [DATA_W-1:0] O_St_Data,
    input  logic [DATA_W-1:0] I_Ld_Data
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ld_q;
    logic [ADDR_W-1:0] len_q, stride_q, base_q;
    logic              rd_vld_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     occ_q;

    logic fifo_full, fifo_empty, push, pop;
    logic st_fire, ld_fire, beat, last_beat, active;

    assign fifo_full  = (occ_q == DEPTH_C);
    assign fifo_empty = (occ_q == '0);
    assign push       = I_Wr_Valid & ~fifo_full;
    assign pop        = st_fire;

    assign st_fire   = (state_q == S_XFER) & ~ld_q & I_St_Grant & I_St_Ready & ~fifo_empty;
    assign ld_fire   = (state_q == S_XFER) &  ld_q & I_Ld_Grant & I_Ld_Ready;
    assign beat      = st_fire | ld_fire;
    assign last_beat = beat & (cnt_q == len_q - ONE_A);
    assign active    = (state_q == S_REQ) | (state_q == S_XFER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_Cmd_Valid) begin
                    cnt_d   = '0;
                    state_d = (I_Cmd_Length == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (ld_q ? I_Ld_Grant : I_St_Grant) state_d = S_XFER;
            end
            S_XFER: begin
                if (beat) cnt_d = cnt_q + ONE_A;
                // Loads spend one extra cycle so the final return lands before O_Done.
                if (last_beat) state_d = ld_q ? S_DRAIN : S_DONE;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ld_q     <= 1'b0;
            len_q    <= '0;
            stride_q <= '0;
            base_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= ld_fire;
            if (state_q == S_IDLE && I_Cmd_Valid) begin
                ld_q     <= I_Cmd_Ld;
                len_q    <= I_Cmd_Length;
                stride_q <= I_Cmd_Stride;
                base_q   <= I_Cmd_Base;
            end
        end
    end

    // Store-data FIFO; storage needs no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= I_Wr_Data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign O_Cmd_Ready = (state_q == S_IDLE);
    assign O_Wr_Ready  = ~fifo_full;
    assign O_Done      = (state_q == S_DONE);
    assign O_St_Req    = active & ~ld_q;
    assign O_Ld_Req    = active &  ld_q;
    assign O_Length    = active ? len_q    : '0;
    assign O_Stride    = active ? stride_q : '0;
    assign O_Base_Addr = active ? base_q   : '0;
    assign O_St_Valid  = st_fire;
    assign O_Ld_Valid  = ld_fire;
    assign O_St_Data   = st_fire ? mem_q[rd_ptr_q] : '0;
    // DMem presents load data one cycle after the beat; pass it straight through.
    assign O_Rd_Valid  = rd_vld_q;
    assign O_Rd_Data   = rd_vld_q ? I_Ld_Data : '0;

endmodule

// File: tb/tb_ldst_initiator.sv
// Directed bench for ldst_initiator: command table plus hand-written stall,
// underflow, FIFO-full and mid-transfer reset sequences.
module tb_ldst_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Cmd_Valid, I_Cmd_Ld;
    logic [31:0] I_Cmd_Length, I_Cmd_Stride, I_Cmd_Base;
    logic        O_Cmd_Ready;
    logic        I_Wr_Valid;
    logic [31:0] I_Wr_Data;
    logic        O_Wr_Ready, O_Rd_Valid, O_Done, O_St_Req, O_Ld_Req;
    logic [31:0] O_Rd_Data, O_Length, O_Stride, O_Base_Addr, O_St_Data, I_Ld_Data;
    logic        I_St_Grant, I_Ld_Grant, I_St_Ready, I_Ld_Ready, O_St_Valid, O_Ld_Valid;

    ldst_initiator #(.FIFO_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .I_Cmd_Valid(I_Cmd_Valid), .I_Cmd_Ld(I_Cmd_Ld), .I_Cmd_Length(I_Cmd_Length),
        .I_Cmd_Stride(I_Cmd_Stride), .I_Cmd_Base(I_Cmd_Base), .O_Cmd_Ready(O_Cmd_Ready),
        .I_Wr_Valid(I_Wr_Valid), .I_Wr_Data(I_Wr_Data), .O_Wr_Ready(O_Wr_Ready),
        .O_Rd_Valid(O_Rd_Valid), .O_Rd_Data(O_Rd_Data), .O_Done(O_Done),
        .O_St_Req(O_St_Req), .O_Ld_Req(O_Ld_Req), .O_Length(O_Length),
        .O_Stride(O_Stride), .O_Base_Addr(O_Base_Addr),
        .I_St_Grant(I_St_Grant), .I_Ld_Grant(I_Ld_Grant),
        .I_St_Ready(I_St_Ready), .I_Ld_Ready(I_Ld_Ready),
        .O_St_Valid(O_St_Valid), .O_Ld_Valid(O_Ld_Valid),
        .O_St_Data(O_St_Data), .I_Ld_Data(I_Ld_Data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic [31:0] len, stride, base;
        int          exp_beats;
        int          exp_done;   // cycles from accept to the O_Done cycle
    } vec_t;

    int n_chk = 0, n_fail = 0;

    int          st_beats, ld_beats, done_cnt, ld_idx;
    logic        st_req_seen, ld_req_seen, prev_ldv, ld_pend, cfg_cap;
    logic [31:0] ld_pend_data, cfg_len, cfg_str, cfg_base;
    logic [31:0] st_q[$], rd_q[$], exp_st[$];
    logic        s_cmd_rdy, s_wr_rdy, s_done, s_st_req, s_ld_req, s_ldv, s_stv;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_mon();
        st_beats = 0; ld_beats = 0; done_cnt = 0; ld_idx = 0;
        st_req_seen = 0; ld_req_seen = 0; prev_ldv = 0; ld_pend = 0; cfg_cap = 0;
        st_q.delete(); rd_q.delete(); exp_st.delete();
    endtask

    // Sample on the falling edge, then step past the rising edge; also models DMem load data.
    task automatic tick();
        @(negedge clock);
        s_cmd_rdy = O_Cmd_Ready; s_wr_rdy = O_Wr_Ready; s_done = O_Done;
        s_st_req = O_St_Req; s_ld_req = O_Ld_Req; s_ldv = O_Ld_Valid; s_stv = O_St_Valid;
        if (O_St_Valid) begin
            st_q.push_back(O_St_Data); st_beats++;
            check("st_valid_has_req", O_St_Req, 1);
        end
        if (O_Ld_Valid) begin
            ld_beats++; ld_pend = 1; ld_pend_data = 32'hA + ld_idx; ld_idx++;
            check("ld_valid_has_req", O_Ld_Req, 1);
        end
        if (O_Rd_Valid) begin
            rd_q.push_back(O_Rd_Data);
            check("rd_one_after_beat", prev_ldv, 1);
        end
        if (O_Done) done_cnt++;
        if (O_St_Req || O_Ld_Req) begin
            if (!cfg_cap) begin
                cfg_cap = 1; cfg_len = O_Length; cfg_str = O_Stride; cfg_base = O_Base_Addr;
            end else begin
                check("cfg_stable", (O_Length == cfg_len && O_Stride == cfg_str &&
                                     O_Base_Addr == cfg_base), 1);
            end
        end
        st_req_seen |= O_St_Req;
        ld_req_seen |= O_Ld_Req;
        prev_ldv = O_Ld_Valid;
        @(posedge clock); #1;
        I_Ld_Data = ld_pend ? ld_pend_data : 32'h0;
        ld_pend = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, O_Cmd_Ready, 1);
        check({tag, "_wr_ready"}, O_Wr_Ready, 1);
        check({tag, "_ctrl_zero"}, {O_St_Req, O_Ld_Req, O_St_Valid, O_Ld_Valid, O_Rd_Valid, O_Done}, 0);
        check({tag, "_data_zero"}, O_Length | O_Stride | O_Base_Addr | O_St_Data | O_Rd_Data, 0);
    endtask

    task automatic push_words(input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            I_Wr_Valid = 1; I_Wr_Data = d0 + i;
            exp_st.push_back(d0 + i);
            tick();
            check("push_ready", s_wr_rdy, 1);
        end
        I_Wr_Valid = 0;
    endtask

    task automatic start_cmd(input logic ld, input logic [31:0] len, input logic [31:0] stride,
                             input logic [31:0] base);
        I_Cmd_Ld = ld; I_Cmd_Length = len; I_Cmd_Stride = stride; I_Cmd_Base = base;
        I_Cmd_Valid = 1;
        tick();
        check("cmd_accept_ready", s_cmd_rdy, 1);
        I_Cmd_Valid = 0;
    endtask

    task automatic wait_done(output int done_at);
        done_at = -1;
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            tick();
            if (s_done) done_at = n;
        end
        if (done_at < 0) check("done_timeout", 0, 1);
    endtask

    vec_t tbl[7];
    int   done_at, pushed, occ, stall_left, gstall;
    logic stalled, gdrop, push_now, req_after_rst;

    initial begin
        tbl[0] = '{1'b0, 32'd4, 32'd1, 32'h10,  4, 6};
        tbl[1] = '{1'b1, 32'd3, 32'd2, 32'h100, 3, 6};
        tbl[2] = '{1'b0, 32'd1, 32'd4, 32'h20,  1, 3};
        tbl[3] = '{1'b1, 32'd1, 32'd1, 32'h40,  1, 4};
        tbl[4] = '{1'b0, 32'd0, 32'd1, 32'h50,  0, 1};
        tbl[5] = '{1'b1, 32'd0, 32'd3, 32'h60,  0, 1};
        tbl[6] = '{1'b1, 32'd2, 32'd8, 32'h200, 2, 5};

        reset = 1; I_Cmd_Valid = 0; I_Cmd_Ld = 0; I_Cmd_Length = 0; I_Cmd_Stride = 0;
        I_Cmd_Base = 0; I_Wr_Valid = 0; I_Wr_Data = 0; I_Ld_Data = 0;
        I_St_Grant = 1; I_Ld_Grant = 1; I_St_Ready = 1; I_Ld_Ready = 1;
        clear_mon();
        tick(); tick();
        check_reset_vals("reset");
        reset = 0;
        tick();

        // Command table with grant and ready held high.
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            if (!tbl[i].ld) push_words(int'(tbl[i].len), 32'hC000 + 32'(i * 16));
            start_cmd(tbl[i].ld, tbl[i].len, tbl[i].stride, tbl[i].base);
            wait_done(done_at);
            check($sformatf("t%0d_done_cycle", i), done_at, tbl[i].exp_done);
            check($sformatf("t%0d_beats", i), tbl[i].ld ? ld_beats : st_beats, tbl[i].exp_beats);
            check($sformatf("t%0d_other_beats", i), tbl[i].ld ? st_beats : ld_beats, 0);
            check($sformatf("t%0d_done_once", i), done_cnt, 1);
            if (tbl[i].len == 0) begin
                check($sformatf("t%0d_no_req", i), {st_req_seen, ld_req_seen}, 2'b00);
            end else begin
                check($sformatf("t%0d_req_kind", i), {st_req_seen, ld_req_seen},
                      tbl[i].ld ? 2'b01 : 2'b10);
                check($sformatf("t%0d_cfg_len", i), cfg_len, tbl[i].len);
                check($sformatf("t%0d_cfg_stride", i), cfg_str, tbl[i].stride);
                check($sformatf("t%0d_cfg_base", i), cfg_base, tbl[i].base);
            end
            if (tbl[i].ld) begin
                check($sformatf("t%0d_returns", i), rd_q.size(), tbl[i].exp_beats);
                for (int k = 0; k < rd_q.size(); k++)
                    check($sformatf("t%0d_rd_data%0d", i, k), rd_q[k], 32'hA + k);
            end else begin
                check($sformatf("t%0d_no_returns", i), rd_q.size(), 0);
                for (int k = 0; k < st_q.size() && k < exp_st.size(); k++)
                    check($sformatf("t%0d_st_data%0d", i, k), st_q[k], exp_st[k]);
            end
            tick();
            check($sformatf("t%0d_ready_after_done", i), s_cmd_rdy, 1);
        end

        // Store with empty FIFO, one word pushed every other cycle.
        clear_mon(); pushed = 0; occ = 0; done_at = -1;
        start_cmd(1'b0, 32'd4, 32'd1, 32'h30);
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            push_now = (pushed < 4) && (n % 2 == 1);
            I_Wr_Valid = push_now; I_Wr_Data = 32'hE0 + pushed;
            if (push_now) begin exp_st.push_back(32'hE0 + pushed); pushed++; end
            tick();
            if (s_stv) begin check("trickle_no_underflow", occ > 0, 1); occ--; end
            if (push_now) occ++;
            if (s_done) done_at = n;
        end
        I_Wr_Valid = 0;
        if (done_at < 0) check("trickle_done_timeout", 0, 1);
        check("trickle_beats", st_beats, 4);
        for (int k = 0; k < 4 && k < st_q.size(); k++)
            check($sformatf("trickle_data%0d", k), st_q[k], exp_st[k]);

        // Load with ready stall after beat 2 and a grant drop after beat 3.
        clear_mon(); stall_left = 2; gstall = 1; done_at = -1;
        start_cmd(1'b1, 32'd4, 32'd1, 32'h80);
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            stalled = (ld_beats == 2) && (stall_left > 0);
            gdrop   = (ld_beats == 3) && (gstall > 0);
            if (stalled) stall_left--;
            if (gdrop) gstall--;
            I_Ld_Ready = !stalled; I_Ld_Grant = !gdrop;
            tick();
            if (stalled || gdrop) begin
                check("stall_req_held", s_ld_req, 1);
                check("stall_no_beat", s_ldv, 0);
            end
            if (s_done) done_at = n;
        end
        I_Ld_Ready = 1; I_Ld_Grant = 1;
        if (done_at < 0) check("stall_done_timeout", 0, 1);
        check("stall_beats", ld_beats, 4);
        check("stall_returns", rd_q.size(), 4);
        for (int k = 0; k < 4 && k < rd_q.size(); k++)
            check($sformatf("stall_rd_data%0d", k), rd_q[k], 32'hA + k);

        // FIFO full: five pushes with no store active.
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            I_Wr_Valid = 1; I_Wr_Data = 32'h50 + i;
            tick();
            check($sformatf("full_ready%0d", i), s_wr_rdy, (i < 4) ? 1 : 0);
        end
        I_Wr_Valid = 0;
        exp_st = '{32'h50, 32'h51, 32'h52, 32'h53};
        start_cmd(1'b0, 32'd4, 32'd1, 32'h0);
        wait_done(done_at);
        check("full_drain_beats", st_beats, 4);
        for (int k = 0; k < 4 && k < st_q.size(); k++)
            check($sformatf("full_drain_data%0d", k), st_q[k], exp_st[k]);

        // Reset during a Length=8 store after beat 3.
        clear_mon();
        push_words(4, 32'h60);
        start_cmd(1'b0, 32'd8, 32'd1, 32'h90);
        for (int n = 0; n < 40 && st_beats < 3; n++) begin
            I_St_Ready = (st_beats < 3);
            tick();
        end
        I_St_Ready = 0;
        check("midrst_reached_beat3", st_beats, 3);
        reset = 1;
        tick();
        check("midrst_no_extra_beat", st_beats, 3);
        check_reset_vals("midrst");
        reset = 0; I_St_Ready = 1; req_after_rst = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            req_after_rst |= s_st_req | s_ld_req;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_req", req_after_rst, 0);
        clear_mon();
        push_words(1, 32'h77);
        start_cmd(1'b0, 32'd1, 32'd1, 32'h0);
        wait_done(done_at);
        check("midrst_fifo_discarded", (st_q.size() > 0) ? st_q[0] : 32'hDEAD, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ldst_initiator.md
LDST_INITIATOR -- requirements
Module: ldst_initiator

Interface
REQ-001 Parameter FIFO_DEPTH, 4, store-data FIFO entries (power of two, >=2).
REQ-002 clock  in  1  single clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 I_Cmd_Valid  in  1  lane command valid.
REQ-005 I_Cmd_Ld  in  1  1=load, 0=store.
REQ-006 I_Cmd_Length / I_Cmd_Stride / I_Cmd_Base  in  address_t each  beat count, stride, base address.
REQ-007 O_Cmd_Ready  out  1  command accepted when I_Cmd_Valid & O_Cmd_Ready.
REQ-008 I_Wr_Valid  in  1, I_Wr_Data  in  data_t, O_Wr_Ready  out  1  store-data push port.
REQ-009 O_Rd_Valid  out  1, O_Rd_Data  out  data_t  load-data return, no backpressure.
REQ-010 O_Done  out  1  one-cycle pulse at command completion.
REQ-011 O_St_Req / O_Ld_Req  out  1  request to DMem store/load port.
REQ-012 O_Length / O_Stride / O_Base_Addr  out  address_t  access config to DMem, shared by both ports.
REQ-013 I_St_Grant / I_Ld_Grant  in  1  grant from DMem.
REQ-014 I_St_Ready / I_Ld_Ready  in  1  DMem ready to transfer.
REQ-015 O_St_Valid / O_Ld_Valid  out  1  beat valid to DMem.
REQ-016 O_St_Data  out  data_t  store beat data; I_Ld_Data  in  data_t  load data from DMem.

Function
REQ-017 FSM states IDLE, REQ, XFER, DRAIN, DONE; only IDLE asserts O_Cmd_Ready.
REQ-018 IDLE: on accept, latch Ld/Length/Stride/Base and go to REQ; Length==0 goes straight to DONE with no DMem request.
REQ-019 REQ: assert O_St_Req or O_Ld_Req per latched type, drive latched config; on matching grant go to XFER.
REQ-020 Request and config outputs held stable from REQ until the final beat issues; request drops the cycle after the final beat.
REQ-021 Store beat issues when state XFER & I_St_Grant & I_St_Ready & FIFO non-empty: O_St_Valid=1, O_St_Data=FIFO head, pop same cycle.
REQ-022 Load beat issues when state XFER & I_Ld_Grant & I_Ld_Ready: O_Ld_Valid=1.
REQ-023 Load data return: O_Rd_Valid=1 and O_Rd_Data=I_Ld_Data exactly one cycle after each issued load beat.
REQ-024 Beat counter (address_t) clears on accept, increments per issued beat; final beat = counter==Length-1.
REQ-025 After final beat: store goes to DONE; load goes to DRAIN for one cycle (last return), then DONE.
REQ-026 DONE: O_Done=1 for one cycle, return to IDLE.
REQ-027 Grant loss in XFER stalls issue, counter holds, request stays asserted; no beat is dropped or duplicated.
REQ-028 Store FIFO: push when I_Wr_Valid & O_Wr_Ready; O_Wr_Ready = ~full; accepts pushes in any state, including before the store command.
REQ-029 Simultaneous push and pop when full is not allowed (O_Wr_Ready=0); when empty, push data is visible at head the next cycle, never the same cycle.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
REQ-031 O_St_Valid/O_Ld_Valid never asserted outside XFER; O_Rd_Valid never asserted for a store.

Reset
REQ-032 Reset forces IDLE, counter=0, FIFO empty, pointers=0.
REQ-033 Reset values: O_Cmd_Ready=1, O_Wr_Ready=1, all requests/valids/O_Done/O_Rd_Valid=0, data/config outputs=0.
REQ-034 Reset mid-transfer abandons the command: no O_Done, request drops the next cycle, FIFO contents discarded.

Verification
REQ-035 Store Length=4, Stride=1, Base=0x10, 4 words pre-pushed, grant+ready held -> 4 consecutive O_St_Valid beats in push order, O_St_Req drops after beat 4, O_Done 1 cycle later.
REQ-036 Load Length=3, grant+ready held, I_Ld_Data=0xA,0xB,0xC -> O_Rd_Valid on 3 cycles, each one cycle after O_Ld_Valid, data 0xA,0xB,0xC; DRAIN then O_Done.
REQ-037 Store Length=4, FIFO empty at grant, 1 word pushed every other cycle -> beats issue only when non-empty, exactly 4 beats, no underflow.
REQ-038 Load Length=4, I_Ld_Ready dropped 2 cycles after beat 2 -> counter holds at 2, O_Ld_Req stays high, resumes, total 4 beats and 4 returns.
REQ-039 Command with Length=0 -> no O_St_Req/O_Ld_Req, O_Done the cycle after accept, O_Cmd_Ready high again the following cycle.
REQ-040 FIFO_DEPTH=4: push 5 words with no store active -> O_Wr_Ready=0 after 4 pushes; reset during a Length=8 store after beat 3 -> all outputs at reset values, no O_Done.
